// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Shares one SPI master engine among NREQ requesters. Grants
//               one requester at a time, latches its word and clear request,
//               pulses the engine start, follows the engine slave-select to
//               detect completion and returns the received word with a
//               one-cycle done pulse.
// Options     : SPI_ARB_FIXED_PRIO_EN - fixed priority (lowest index wins)
//               instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
   parameter int BITS = 8,
   parameter int NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_clr,
   input  logic [NREQ*BITS-1:0] req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [BITS-1:0]      rdata,
   output logic                 busy,
   output logic                 spi_en,
   output logic                 spi_clr_ctrl,
   output logic [BITS-1:0]      spi_data2trans,
   input  logic                 spi_ss,
   input  logic [BITS-1:0]      spi_data_rec
);

   localparam int IW  = $clog2(NREQ);
   localparam int IW1 = IW + 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_LOW  = 3'd2,
      S_WAIT_HIGH = 3'd3,
      S_CAPTURE   = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t          state;
   logic [IW-1:0]   sel_idx;
   logic [BITS-1:0] data_q;
   logic            clr_q;

`ifndef SPI_ARB_FIXED_PRIO_EN
   logic [IW-1:0]   ptr;
   logic [IW:0]     cand;
   logic            found;
`endif

   // The engine sees only the latched copy, so requester-side changes after
   // the grant cannot disturb a transfer in flight.
   assign spi_data2trans = data_q;
   assign spi_clr_ctrl   = clr_q;

   // Select the next winner among the currently active requests
   always_comb begin
      sel_idx = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
      // Descending scan: the last hit is the lowest set index.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) sel_idx = IW'(i);
      end
`else
      cand  = '0;
      found = 1'b0;
      // Scan starts one past the last winner and wraps modulo NREQ; a single
      // subtraction suffices because ptr + 1 + i < 2*NREQ.
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + IW1'(i + 1);
         if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
         if (!found && req[cand[IW-1:0]]) begin
            sel_idx = cand[IW-1:0];
            found   = 1'b1;
         end
      end
`endif
   end

   // Transaction FSM with registered grant, start, done and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         gnt    <= '0;
         done   <= '0;
         rdata  <= '0;
         busy   <= 1'b0;
         spi_en <= 1'b0;
         data_q <= '0;
         clr_q  <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
         ptr    <= IW'(NREQ - 1);
`endif
      end else begin
         spi_en <= 1'b0;
         done   <= '0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  gnt    <= NREQ'(1) << sel_idx;
                  data_q <= req_data[sel_idx*BITS +: BITS];
                  clr_q  <= req_clr[sel_idx];
                  busy   <= 1'b1;
                  spi_en <= 1'b1;
`ifndef SPI_ARB_FIXED_PRIO_EN
                  ptr    <= sel_idx;
`endif
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
               // Slave-select stays high through a long clear phase.
               if (!spi_ss) state <= S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               if (spi_ss) state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // Engine refreshes its receive register during this cycle.
               state <= S_DONE;
               rdata <= spi_data_rec;
               done  <= gnt;
            end
            S_DONE: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Self-checking bench for spi_arbiter with a behavioural SPI
//               engine (loopback of a chosen MISO word) and an arbitration
//               reference model. Honours SPI_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
   localparam int BITS = 8;
   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, req_clr, gnt, done;
   logic [31:0] req_data;
   logic [7:0]  rdata, spi_data2trans, spi_data_rec;
   logic        busy, spi_en, spi_clr_ctrl, spi_ss;

   always #5 clk = ~clk;

   spi_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req(req), .req_clr(req_clr), .req_data(req_data),
      .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .spi_en(spi_en),
      .spi_clr_ctrl(spi_clr_ctrl), .spi_data2trans(spi_data2trans),
      .spi_ss(spi_ss), .spi_data_rec(spi_data_rec)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         last_win = NREQ - 1;
   int         clr_cycles = 40;
   logic [7:0] miso_word = 8'h00;
   int         en_count = 0;
   int         sclk_count = 0;
   logic [7:0] mosi_word = 8'h00;

   // Behavioural engine: acts 2 time units after each rising edge
   initial begin : engine
      int st, cnt;
      logic [7:0] rx;
      st = 0; cnt = 0; rx = 8'h00;
      spi_ss = 1'b1; spi_data_rec = 8'h00;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            st = 0; spi_ss = 1'b1; spi_data_rec = 8'h00;
         end else begin
            if (spi_en) en_count++;
            case (st)
               0: if (spi_en) begin
                     rx = miso_word; mosi_word = 8'h00; sclk_count = 0;
                     cnt = spi_clr_ctrl ? clr_cycles : 2; st = 1;
                  end
               1: begin
                     cnt--;
                     if (cnt <= 0) begin spi_ss = 1'b0; st = 2; end
                  end
               2: begin
                     mosi_word = {mosi_word[6:0], spi_data2trans[7-sclk_count]};
                     sclk_count++;
                     if (sclk_count == 8) begin spi_ss = 1'b1; st = 3; end
                  end
               default: begin spi_data_rec = rx; st = 0; end
            endcase
         end
      end
   end

   // Reference arbitration rule
   function automatic int model_pick(input logic [3:0] r, input int last);
`ifdef SPI_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
      return 0;
   endfunction

   // One full transaction; called at a falling edge with the DUT idle and req set
   task automatic run_txn(input string name, input logic [7:0] miso,
                          input logic [3:0] mid_req, input logic [31:0] mid_data);
      int win, en0, since_hi;
      logic [3:0] exp_oh;
      logic [7:0] exp_tx;
      logic exp_clr, got, seen_low;
      win = model_pick(req, last_win);
      exp_oh = 4'b0001 << win;
      exp_tx = req_data[win*8 +: 8];
      exp_clr = req_clr[win];
      last_win = win;
      miso_word = miso;
      en0 = en_count;
      @(negedge clk);
      n_checks++; if (gnt !== exp_oh) begin n_fail++; $display("FAIL %s grant: got %b want %b", name, gnt, exp_oh); end
      n_checks++; if (spi_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL %s issue: spi_en=%b busy=%b want 1 1", name, spi_en, busy); end
      n_checks++; if (spi_data2trans !== exp_tx || spi_clr_ctrl !== exp_clr) begin n_fail++; $display("FAIL %s latch: tx=%h clr=%b want %h %b", name, spi_data2trans, spi_clr_ctrl, exp_tx, exp_clr); end
      req = mid_req;
      req_data = mid_data;
      @(negedge clk);
      n_checks++; if (spi_en !== 1'b0) begin n_fail++; $display("FAIL %s spi_en width: got %b want 0", name, spi_en); end
      got = 1'b0; seen_low = 1'b0; since_hi = -1;
      for (int c = 0; c < clr_cycles + 100 && !got; c++) begin
         @(negedge clk);
         n_checks++;
         if ($countones(done) > 1 || (done & ~gnt) != 4'b0 || gnt !== exp_oh || busy !== 1'b1) begin
            n_fail++; $display("FAIL %s invariant: gnt=%b done=%b busy=%b want gnt %b", name, gnt, done, busy, exp_oh);
         end
         if (since_hi >= 0) since_hi++;
         else if (spi_ss === 1'b1 && seen_low) since_hi = 0;
         if (spi_ss === 1'b0) seen_low = 1'b1;
         if (done !== 4'b0) got = 1'b1;
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL %s timeout: done=%b want %b", name, done, exp_oh); end
      n_checks++; if (done !== exp_oh) begin n_fail++; $display("FAIL %s done: got %b want %b", name, done, exp_oh); end
      n_checks++; if (rdata !== miso) begin n_fail++; $display("FAIL %s rdata: got %h want %h", name, rdata, miso); end
      n_checks++; if (since_hi != 2) begin n_fail++; $display("FAIL %s done latency: got %0d want 2", name, since_hi); end
      n_checks++; if (mosi_word !== exp_tx || sclk_count != 8) begin n_fail++; $display("FAIL %s mosi: got %h/%0d bits want %h/8", name, mosi_word, sclk_count, exp_tx); end
      n_checks++; if (en_count - en0 != 1) begin n_fail++; $display("FAIL %s spi_en count: got %0d want 1", name, en_count - en0); end
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0 || rdata !== miso) begin
         n_fail++; $display("FAIL %s idle: gnt=%b busy=%b done=%b rdata=%h want 0 0 0 %h", name, gnt, busy, done, rdata, miso);
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({gnt, done, rdata, busy, spi_en, spi_clr_ctrl, spi_data2trans} !== 31'b0) begin
         n_fail++; $display("FAIL %s outputs: gnt=%b done=%b rdata=%h busy=%b en=%b clr=%b tx=%h want all 0",
                            name, gnt, done, rdata, busy, spi_en, spi_clr_ctrl, spi_data2trans);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b0; req_clr = 4'b0; req_data = 32'h0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      last_win = NREQ - 1;
      @(negedge clk);
      check_zero("post_reset");
   endtask

   task automatic test_all_held();
      int exp_seq [4];
      req_data = 32'h44332211; req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
         exp_seq[i] = 0;
`else
         exp_seq[i] = i;
`endif
         n_checks++; if (model_pick(req, last_win) != exp_seq[i]) begin n_fail++; $display("FAIL all_held order: got %0d want %0d", model_pick(req, last_win), exp_seq[i]); end
         run_txn("all_held", 8'h10 + 8'(i), 4'b1111, req_data);
      end
      req = 4'b0;
   endtask

   task automatic test_single();
      req_data = 32'h000000A5; req = 4'b0001;
      run_txn("single", 8'h3C, 4'b0001, req_data);
      req = 4'b0;
   endtask

   task automatic test_clear();
      clr_cycles = 25000;
      req_data = 32'h00C30000; req_clr = 4'b0100; req = 4'b0100;
      run_txn("clear", 8'h96, 4'b0100, req_data);
      req = 4'b0; req_clr = 4'b0; clr_cycles = 40;
   endtask

   task automatic test_data_stability();
      req_data = 32'h00005A00; req = 4'b0010;
      run_txn("data_stability", 8'hE1, 4'b0000, 32'h0000FF00);
   endtask

   task automatic test_late_contender();
      req_data = 32'h00007700 | 32'h00000066; req = 4'b0001;
      run_txn("late_first", 8'h01, 4'b0011, req_data);
      run_txn("late_second", 8'h02, 4'b0011, req_data);
      req = 4'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         req      = 4'($urandom_range(1, 15));
         req_clr  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         req_data = $urandom;
         run_txn("random", 8'($urandom), 4'($urandom_range(0, 15)), $urandom);
      end
      req = 4'b0; req_clr = 4'b0;
   endtask

   task automatic test_reset_mid();
      logic low;
      req_data = 32'h00000081; req = 4'b0001;
      last_win = model_pick(req, last_win);
      @(negedge clk);
      low = 1'b0;
      for (int c = 0; c < 50 && !low; c++) begin
         @(negedge clk);
         if (spi_ss === 1'b0) low = 1'b1;
      end
      n_checks++; if (!low) begin n_fail++; $display("FAIL reset_mid ss: got %b want 0", spi_ss); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_zero("reset_mid");
      repeat (3) @(negedge clk);
      check_zero("reset_mid_held");
      rst = 1'b0;
      last_win = NREQ - 1;
      run_txn("after_reset", 8'h5B, 4'b0001, req_data);
      req = 4'b0;
   endtask

   initial begin
      test_reset();
      test_all_held();
      test_single();
      test_clear();
      test_data_stability();
      test_late_contender();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
